// File: rtl/sparse_mask_pkg.sv
// Shared types and helpers for the sparse-operand mask path (operand matcher and index decoder).
package sparse_mask_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    EMIT = 1'b1
  } state_e;

  localparam int DEFAULT_MASK_LENGTH = 8;
  localparam int MAX_MASK_LENGTH     = 64;

  // Position of the lowest set bit; 0 when the mask is all-zero.
  function automatic int lowest_set_bit(input logic [MAX_MASK_LENGTH-1:0] mask);
    int pos;
    pos = 0;
    for (int i = MAX_MASK_LENGTH - 1; i >= 0; i--) begin
      if (mask[i]) pos = i;
    end
    return pos;
  endfunction

endpackage

// File: rtl/lowest_bit_encoder.sv
// Priority encoder: index of the lowest set bit of a mask, plus a found flag.
module lowest_bit_encoder
  import sparse_mask_pkg::*;
#(
  parameter int BITMASK_LENGTH = DEFAULT_MASK_LENGTH,
  parameter int INDEX_WIDTH    = $clog2(BITMASK_LENGTH)
) (
  input  logic [BITMASK_LENGTH-1:0] mask_i,
  output logic [INDEX_WIDTH-1:0]    index_o,
  output logic                      found_o
);

  assign index_o = INDEX_WIDTH'(lowest_set_bit(MAX_MASK_LENGTH'(mask_i)));
  assign found_o = |mask_i;

endmodule

// File: rtl/sparse_mask_index_decoder.sv
// Walks a sparse-operand bitmask and emits one set-bit index per beat (valid/ready).
// Optional macro SPARSE_MASK_DECODER_BACK_TO_BACK_EN lets a new mask load on the final beat.
module sparse_mask_index_decoder
  import sparse_mask_pkg::*;
#(
  parameter int BITMASK_LENGTH = DEFAULT_MASK_LENGTH,
  parameter int INDEX_WIDTH    = $clog2(BITMASK_LENGTH)
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      ivalid,
  output logic                      oready,
  input  logic [BITMASK_LENGTH-1:0] bitmask,
  output logic                      ovalid,
  input  logic                      iready,
  output logic [INDEX_WIDTH-1:0]    index,
  output logic [INDEX_WIDTH-1:0]    ordinal,
  output logic                      last,
  output logic                      empty
);

  localparam logic [BITMASK_LENGTH-1:0] ONE = BITMASK_LENGTH'(1);

  state_e                    state_q, state_d;
  logic [BITMASK_LENGTH-1:0] residual_q, residual_d;
  logic [INDEX_WIDTH-1:0]    ordinal_q, ordinal_d;
  logic [INDEX_WIDTH-1:0]    low_idx;
  logic                      found;
  logic                      emit, single, accept, beat;

  lowest_bit_encoder #(
    .BITMASK_LENGTH(BITMASK_LENGTH),
    .INDEX_WIDTH   (INDEX_WIDTH)
  ) u_enc (
    .mask_i (residual_q),
    .index_o(low_idx),
    .found_o(found)
  );

  assign emit   = (state_q == EMIT);
  // x & (x-1) drops the lowest set bit; zero result means at most one bit was set.
  assign single = ((residual_q & (residual_q - ONE)) == '0);

  assign ovalid  = emit;
  assign index   = low_idx;
  assign ordinal = ordinal_q;
  assign last    = emit && single;
  assign empty   = emit && !found;

`ifdef SPARSE_MASK_DECODER_BACK_TO_BACK_EN
  assign oready = !reset && (!emit || (last && iready));
`else
  assign oready = !reset && !emit;
`endif

  assign accept = ivalid && oready;
  assign beat   = ovalid && iready;

  always_comb begin
    state_d    = state_q;
    residual_d = residual_q;
    ordinal_d  = ordinal_q;
    if (accept) begin
      state_d    = EMIT;
      residual_d = bitmask;
      ordinal_d  = '0;
    end else if (beat) begin
      residual_d = residual_q & (residual_q - ONE);
      if (last) state_d = IDLE;
      else      ordinal_d = ordinal_q + INDEX_WIDTH'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= IDLE;
      residual_q <= '0;
      ordinal_q  <= '0;
    end else begin
      state_q    <= state_d;
      residual_q <= residual_d;
      ordinal_q  <= ordinal_d;
    end
  end

endmodule
